// File: rtl/id_stage_p.sv
// ---------------------------------------------------------------------------
// id_stage_p : RISC-V instruction-decode stage
//
// Holds the F->ID pipeline register, the architectural register file and the
// combinational decoder that turns the registered instruction into control
// strobes, operands and a sign-extended immediate.
//
// Parameters
//   XLEN     : datapath width (32 or 64)
//   NUM_REGS : architectural register count (16 or 32)
//
// Optional feature
//   ID_WB_BYPASS_EN : when defined, a register read that hits the register
//                     being written back this cycle returns i_result_WB.
//
// Ports
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_instr_F, i_pc_F,
//   i_pc_plus4_F          : fetch-stage instruction / PC / PC+4
//   i_stall_D, i_flush_D  : hold ID register / replace it with a bubble
//   i_result_WB,
//   i_addr_des_WB,
//   i_reg_write_WB        : writeback data, destination and enable
//   o_valid_ID            : ID holds a real instruction
//   o_*_ID strobes        : decoded controls (gated by valid / illegal)
//   o_result_src_ID       : 00 ALU, 01 memory, 10 PC+4
//   o_alu_control_ID      : ALU operation code
//   o_illegal_ID          : unknown opcode or out-of-range register
//   o_dataA_ID/o_dataB_ID : register operands
//   o_imm_ext_ID          : sign-extended immediate
//   o_pc_ID/o_pc_plus4_ID : PC and PC+4 of the ID instruction
//   o_addr_src*/o_addr_des_ID : rs1, rs2, rd fields
// ---------------------------------------------------------------------------
module id_stage_p #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [31:0]     i_instr_F,
    input  logic [XLEN-1:0] i_pc_F,
    input  logic [XLEN-1:0] i_pc_plus4_F,
    input  logic            i_stall_D,
    input  logic            i_flush_D,
    input  logic [XLEN-1:0] i_result_WB,
    input  logic [4:0]      i_addr_des_WB,
    input  logic            i_reg_write_WB,
    output logic            o_valid_ID,
    output logic            o_reg_write_ID,
    output logic            o_mem_write_ID,
    output logic            o_jump_ID,
    output logic            o_branch_ID,
    output logic            o_alu_src_ID,
    output logic            o_alu_srcA_pc_ID,
    output logic [1:0]      o_result_src_ID,
    output logic [3:0]      o_alu_control_ID,
    output logic            o_illegal_ID,
    output logic [XLEN-1:0] o_dataA_ID,
    output logic [XLEN-1:0] o_dataB_ID,
    output logic [XLEN-1:0] o_imm_ext_ID,
    output logic [XLEN-1:0] o_pc_ID,
    output logic [XLEN-1:0] o_pc_plus4_ID,
    output logic [4:0]      o_addr_srcA_ID,
    output logic [4:0]      o_addr_srcB_ID,
    output logic [4:0]      o_addr_des_ID
);

    localparam int         AW     = $clog2(NUM_REGS);
    localparam logic [5:0] NREG6  = 6'(NUM_REGS);
    localparam logic [31:0] NOP   = 32'h0000_0013;

`ifdef ID_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    logic [31:0]     instr_p0;
    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] pc4_p0;
    logic            vld_p0;

    logic [XLEN-1:0] regs [NUM_REGS];

    logic            wb_ok;
    logic [4:0]      rs1, rs2, rd;

    assign rs1 = instr_p0[19:15];
    assign rs2 = instr_p0[24:20];
    assign rd  = instr_p0[11:7];

    function automatic logic in_range(input logic [4:0] a);
        return ({1'b0, a} < NREG6);
    endfunction

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b5,
                                          input logic is_r);
        case (f3)
            3'b000:  alu_op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    // Writes are dropped for x0 and for addresses beyond the implemented file.
    assign wb_ok = i_reg_write_WB && (i_addr_des_WB != 5'd0) && in_range(i_addr_des_WB);

    function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] a);
        if (a == 5'd0 || !in_range(a))
            rd_reg = '0;
        else if (BYPASS && wb_ok && (a == i_addr_des_WB))
            rd_reg = i_result_WB;
        else
            rd_reg = regs[a[AW-1:0]];
    endfunction

    // ---- Stage F -> ID: pipeline register and register-file writes ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            instr_p0 <= NOP;
            pc_p0    <= '0;
            pc4_p0   <= '0;
            vld_p0   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (i_flush_D) begin
                instr_p0 <= NOP;
                pc_p0    <= '0;
                pc4_p0   <= '0;
                vld_p0   <= 1'b0;
            end else if (!i_stall_D) begin
                instr_p0 <= i_instr_F;
                pc_p0    <= i_pc_F;
                pc4_p0   <= i_pc_plus4_F;
                vld_p0   <= 1'b1;
            end
            if (wb_ok) regs[i_addr_des_WB[AW-1:0]] <= i_result_WB;
        end
    end

    // ---- Stage ID: combinational decode ----
    logic              d_reg_write, d_mem_write, d_jump, d_branch;
    logic              d_alu_src, d_srca_pc, d_unknown;
    logic              use_rs1, use_rs2, use_rd;
    logic [1:0]        d_result_src;
    logic [3:0]        d_alu_ctl;
    logic signed [31:0] imm32;
    logic              illegal;

    always_comb begin
        d_reg_write  = 1'b0;
        d_mem_write  = 1'b0;
        d_jump       = 1'b0;
        d_branch     = 1'b0;
        d_alu_src    = 1'b0;
        d_srca_pc    = 1'b0;
        d_unknown    = 1'b0;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        use_rd       = 1'b0;
        d_result_src = 2'b00;
        d_alu_ctl    = ALU_ADD;
        imm32        = '0;
        case (instr_p0[6:0])
            OP_R: begin
                d_alu_ctl   = alu_op(instr_p0[14:12], instr_p0[30], 1'b1);
                d_reg_write = 1'b1;
                {use_rs1, use_rs2, use_rd} = 3'b111;
            end
            OP_IALU: begin
                d_alu_ctl   = alu_op(instr_p0[14:12], instr_p0[30], 1'b0);
                d_alu_src   = 1'b1;
                d_reg_write = 1'b1;
                imm32       = {{20{instr_p0[31]}}, instr_p0[31:20]};
                {use_rs1, use_rd} = 2'b11;
            end
            OP_LOAD: begin
                d_alu_src    = 1'b1;
                d_reg_write  = 1'b1;
                d_result_src = 2'b01;
                imm32        = {{20{instr_p0[31]}}, instr_p0[31:20]};
                {use_rs1, use_rd} = 2'b11;
            end
            OP_STORE: begin
                d_alu_src   = 1'b1;
                d_mem_write = 1'b1;
                imm32       = {{20{instr_p0[31]}}, instr_p0[31:25], instr_p0[11:7]};
                {use_rs1, use_rs2} = 2'b11;
            end
            OP_BRANCH: begin
                d_alu_ctl = ALU_SUB;
                d_branch  = 1'b1;
                imm32     = {{19{instr_p0[31]}}, instr_p0[31], instr_p0[7],
                             instr_p0[30:25], instr_p0[11:8], 1'b0};
                {use_rs1, use_rs2} = 2'b11;
            end
            OP_JAL: begin
                d_jump       = 1'b1;
                d_reg_write  = 1'b1;
                d_result_src = 2'b10;
                imm32        = {{11{instr_p0[31]}}, instr_p0[31], instr_p0[19:12],
                                instr_p0[20], instr_p0[30:21], 1'b0};
                use_rd       = 1'b1;
            end
            OP_JALR: begin
                d_jump       = 1'b1;
                d_alu_src    = 1'b1;
                d_reg_write  = 1'b1;
                d_result_src = 2'b10;
                imm32        = {{20{instr_p0[31]}}, instr_p0[31:20]};
                {use_rs1, use_rd} = 2'b11;
            end
            OP_LUI: begin
                d_alu_ctl   = ALU_PASSB;
                d_alu_src   = 1'b1;
                d_reg_write = 1'b1;
                imm32       = {instr_p0[31:12], 12'h000};
                use_rd      = 1'b1;
            end
            OP_AUIPC: begin
                d_alu_src   = 1'b1;
                d_srca_pc   = 1'b1;
                d_reg_write = 1'b1;
                imm32       = {instr_p0[31:12], 12'h000};
                use_rd      = 1'b1;
            end
            default: d_unknown = 1'b1;
        endcase
    end

    // Only register fields the format actually uses can make it illegal.
    assign illegal = vld_p0 && (d_unknown ||
                                (use_rs1 && !in_range(rs1)) ||
                                (use_rs2 && !in_range(rs2)) ||
                                (use_rd  && !in_range(rd)));

    assign o_valid_ID       = vld_p0;
    assign o_illegal_ID     = illegal;
    assign o_reg_write_ID   = vld_p0 && !illegal && d_reg_write;
    assign o_mem_write_ID   = vld_p0 && !illegal && d_mem_write;
    assign o_jump_ID        = vld_p0 && !illegal && d_jump;
    assign o_branch_ID      = vld_p0 && !illegal && d_branch;
    assign o_alu_src_ID     = vld_p0 && d_alu_src;
    assign o_alu_srcA_pc_ID = vld_p0 && d_srca_pc;
    assign o_result_src_ID  = d_result_src;
    assign o_alu_control_ID = d_alu_ctl;
    // Size cast of a signed operand sign-extends to XLEN.
    assign o_imm_ext_ID     = XLEN'(imm32);
    assign o_dataA_ID       = rd_reg(rs1);
    assign o_dataB_ID       = rd_reg(rs2);
    assign o_pc_ID          = pc_p0;
    assign o_pc_plus4_ID    = pc4_p0;
    assign o_addr_srcA_ID   = rs1;
    assign o_addr_srcB_ID   = rs2;
    assign o_addr_des_ID    = rd;

endmodule

// File: tb/tb_id_stage_p.sv
module tb_id_stage_p;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_instr_F;
    logic [31:0] i_pc_F, i_pc_plus4_F;
    logic        i_stall_D, i_flush_D;
    logic [31:0] i_result_WB;
    logic [4:0]  i_addr_des_WB;
    logic        i_reg_write_WB;

    // 32-bit / 32-register instance
    logic        valid, reg_write, mem_write, jump, branch, alu_src, srca_pc, illegal;
    logic [1:0]  result_src;
    logic [3:0]  alu_ctl;
    logic [31:0] dataA, dataB, imm, pc, pc4;
    logic [4:0]  ra, rb, rdes;

    // 64-bit / 16-register instance
    logic        s_valid, s_reg_write, s_mem_write, s_jump, s_branch, s_alu_src, s_srca_pc, s_illegal;
    logic [1:0]  s_result_src;
    logic [3:0]  s_alu_ctl;
    logic [63:0] s_dataA, s_dataB, s_imm, s_pc, s_pc4;
    logic [4:0]  s_ra, s_rb, s_rdes;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 i_clk = ~i_clk;

    id_stage_p #(.XLEN(32), .NUM_REGS(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_instr_F(i_instr_F), .i_pc_F(i_pc_F),
        .i_pc_plus4_F(i_pc_plus4_F), .i_stall_D(i_stall_D), .i_flush_D(i_flush_D),
        .i_result_WB(i_result_WB), .i_addr_des_WB(i_addr_des_WB), .i_reg_write_WB(i_reg_write_WB),
        .o_valid_ID(valid), .o_reg_write_ID(reg_write), .o_mem_write_ID(mem_write),
        .o_jump_ID(jump), .o_branch_ID(branch), .o_alu_src_ID(alu_src),
        .o_alu_srcA_pc_ID(srca_pc), .o_result_src_ID(result_src), .o_alu_control_ID(alu_ctl),
        .o_illegal_ID(illegal), .o_dataA_ID(dataA), .o_dataB_ID(dataB), .o_imm_ext_ID(imm),
        .o_pc_ID(pc), .o_pc_plus4_ID(pc4), .o_addr_srcA_ID(ra), .o_addr_srcB_ID(rb),
        .o_addr_des_ID(rdes)
    );

    id_stage_p #(.XLEN(64), .NUM_REGS(16)) dut16 (
        .i_clk(i_clk), .i_rst(i_rst), .i_instr_F(i_instr_F), .i_pc_F({32'd0, i_pc_F}),
        .i_pc_plus4_F({32'd0, i_pc_plus4_F}), .i_stall_D(i_stall_D), .i_flush_D(i_flush_D),
        .i_result_WB({32'd0, i_result_WB}), .i_addr_des_WB(i_addr_des_WB),
        .i_reg_write_WB(i_reg_write_WB),
        .o_valid_ID(s_valid), .o_reg_write_ID(s_reg_write), .o_mem_write_ID(s_mem_write),
        .o_jump_ID(s_jump), .o_branch_ID(s_branch), .o_alu_src_ID(s_alu_src),
        .o_alu_srcA_pc_ID(s_srca_pc), .o_result_src_ID(s_result_src), .o_alu_control_ID(s_alu_ctl),
        .o_illegal_ID(s_illegal), .o_dataA_ID(s_dataA), .o_dataB_ID(s_dataB), .o_imm_ext_ID(s_imm),
        .o_pc_ID(s_pc), .o_pc_plus4_ID(s_pc4), .o_addr_srcA_ID(s_ra), .o_addr_srcB_ID(s_rb),
        .o_addr_des_ID(s_rdes)
    );

    // {reg_write, mem_write, jump, branch, alu_src, alu_srcA_pc, valid, illegal}
    wire [7:0] strobes   = {reg_write, mem_write, jump, branch, alu_src, srca_pc, valid, illegal};
    wire [7:0] s_strobes = {s_reg_write, s_mem_write, s_jump, s_branch, s_alu_src, s_srca_pc,
                            s_valid, s_illegal};

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load(input logic [31:0] ins, input logic [31:0] p);
        i_instr_F    = ins;
        i_pc_F       = p;
        i_pc_plus4_F = p + 32'd4;
        i_stall_D    = 1'b0;
        i_flush_D    = 1'b0;
        tick();
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        i_addr_des_WB  = a;
        i_result_WB    = d;
        i_reg_write_WB = 1'b1;
        tick();
        i_reg_write_WB = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (strobes !== 8'h00) $display("FAIL reset_strobes: got %b want 00000000", strobes);
        else n_pass++;
        n_checks++;
        if (alu_ctl !== 4'b0000 || imm !== 32'd0)
            $display("FAIL reset_alu_imm: got alu=%b imm=%h want alu=0000 imm=0", alu_ctl, imm);
        else n_pass++;
        n_checks++;
        if (s_strobes !== 8'h00 || s_imm !== 64'd0)
            $display("FAIL reset_strobes_64: got %b imm=%h want 0", s_strobes, s_imm);
        else n_pass++;
        #3 i_rst = 1'b0;
        // first edge after release must take the fetch input
        load(32'h0050_0093, 32'h40);
        n_checks++;
        if (valid !== 1'b1 || pc !== 32'h40 || rdes !== 5'd1)
            $display("FAIL reset_release: got valid=%b pc=%h rd=%0d want 1 40 1", valid, pc, rdes);
        else n_pass++;
    endtask

    task automatic test_regfile_read();
        wb_write(5'd5, 32'hDEAD_BEEF);
        load(32'h0052_8333, 32'h100);             // add x6,x5,x5
        n_checks++;
        if (dataA !== 32'hDEAD_BEEF || dataB !== 32'hDEAD_BEEF)
            $display("FAIL add_operands: got A=%h B=%h want deadbeef", dataA, dataB);
        else n_pass++;
        n_checks++;
        if (alu_ctl !== 4'b0000 || reg_write !== 1'b1 || rdes !== 5'd6 || alu_src !== 1'b0)
            $display("FAIL add_ctrl: got alu=%b rw=%b rd=%0d src=%b want 0000 1 6 0",
                     alu_ctl, reg_write, rdes, alu_src);
        else n_pass++;
        n_checks++;
        if (pc !== 32'h100 || pc4 !== 32'h104)
            $display("FAIL add_pc: got %h/%h want 100/104", pc, pc4);
        else n_pass++;
    endtask

    task automatic test_wb_same_cycle();
        logic [31:0] exp_same;
        wb_write(5'd7, 32'h0000_1111);
        load(32'h0073_8433, 32'h110);             // add x8,x7,x7
        n_checks++;
        if (dataA !== 32'h1111) $display("FAIL x7_old: got %h want 1111", dataA);
        else n_pass++;
`ifdef ID_WB_BYPASS_EN
        exp_same = 32'h0000_1234;
`else
        exp_same = 32'h0000_1111;
`endif
        i_addr_des_WB  = 5'd7;
        i_result_WB    = 32'h0000_1234;
        i_reg_write_WB = 1'b1;
        i_stall_D      = 1'b1;
        #1;
        n_checks++;
        if (dataA !== exp_same || dataB !== exp_same)
            $display("FAIL x7_same_cycle: got A=%h B=%h want %h", dataA, dataB, exp_same);
        else n_pass++;
        tick();
        i_reg_write_WB = 1'b0;
        i_stall_D      = 1'b0;
        #1;
        n_checks++;
        if (dataA !== 32'h1234) $display("FAIL x7_after_write: got %h want 1234", dataA);
        else n_pass++;
    endtask

    task automatic test_stall_flush();
        load(32'h0050_0093, 32'h100);             // addi x1,x0,5
        i_instr_F    = 32'h4031_00B3;
        i_pc_F       = 32'h200;
        i_pc_plus4_F = 32'h204;
        i_stall_D    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (valid !== 1'b1 || pc !== 32'h100 || pc4 !== 32'h104 || rdes !== 5'd1 || imm !== 32'd5)
                $display("FAIL stall_hold_%0d: got v=%b pc=%h pc4=%h rd=%0d imm=%h want 1 100 104 1 5",
                         c, valid, pc, pc4, rdes, imm);
            else n_pass++;
        end
        i_flush_D = 1'b1;
        tick();
        n_checks++;
        if (strobes !== 8'h00 || pc !== 32'd0 || pc4 !== 32'd0 || rdes !== 5'd0 || imm !== 32'd0)
            $display("FAIL stall_flush_bubble: got st=%b pc=%h pc4=%h rd=%0d imm=%h want all 0",
                     strobes, pc, pc4, rdes, imm);
        else n_pass++;
        i_stall_D = 1'b0;
        i_flush_D = 1'b0;
    endtask

    task automatic test_decode();
        load(32'h4031_00B3, 32'h300);             // sub x1,x2,x3
        n_checks++;
        if (alu_ctl !== 4'b0001 || ra !== 5'd2 || rb !== 5'd3)
            $display("FAIL sub: got alu=%b rs1=%0d rs2=%0d want 0001 2 3", alu_ctl, ra, rb);
        else n_pass++;
        load(32'h4031_50B3, 32'h304);             // sra x1,x2,x3
        n_checks++;
        if (alu_ctl !== 4'b1001) $display("FAIL sra: got %b want 1001", alu_ctl);
        else n_pass++;
        load(32'h0051_2423, 32'h308);             // sw x5,8(x2)
        n_checks++;
        if (strobes !== 8'b0100_1010 || imm !== 32'd8 || alu_ctl !== 4'b0000)
            $display("FAIL sw: got st=%b imm=%h alu=%b want 01001010 8 0000", strobes, imm, alu_ctl);
        else n_pass++;
        load(32'hFFC1_2083, 32'h30C);             // lw x1,-4(x2)
        n_checks++;
        if (strobes !== 8'b1000_1010 || imm !== 32'hFFFF_FFFC || result_src !== 2'b01)
            $display("FAIL lw: got st=%b imm=%h rs=%b want 10001010 fffffffc 01",
                     strobes, imm, result_src);
        else n_pass++;
        load(32'h0100_00EF, 32'h310);             // jal x1,16
        n_checks++;
        if (strobes !== 8'b1010_0010 || imm !== 32'd16 || result_src !== 2'b10)
            $display("FAIL jal: got st=%b imm=%h rs=%b want 10100010 10 10", strobes, imm, result_src);
        else n_pass++;
        load(32'h0000_1097, 32'h314);             // auipc x1,1
        n_checks++;
        if (strobes !== 8'b1000_1110 || imm !== 32'h1000 || alu_ctl !== 4'b0000)
            $display("FAIL auipc: got st=%b imm=%h alu=%b want 10001110 1000 0000", strobes, imm, alu_ctl);
        else n_pass++;
        load(32'h0000_007F, 32'h318);             // unknown opcode
        n_checks++;
        if (strobes !== 8'b0000_0011)
            $display("FAIL unknown_op: got st=%b want 00000011", strobes);
        else n_pass++;
    endtask

    task automatic test_imm();
        load(32'hFE20_8CE3, 32'h400);             // beq x1,x2,-8
        n_checks++;
        if (imm !== 32'hFFFF_FFF8 || branch !== 1'b1 || alu_ctl !== 4'b0001 || reg_write !== 1'b0)
            $display("FAIL beq: got imm=%h br=%b alu=%b rw=%b want fffffff8 1 0001 0",
                     imm, branch, alu_ctl, reg_write);
        else n_pass++;
        n_checks++;
        if (s_imm !== 64'hFFFF_FFFF_FFFF_FFF8) $display("FAIL beq_64: got %h want fffffffffffffff8", s_imm);
        else n_pass++;
        load(32'hABCD_E1B7, 32'h404);             // lui x3,0xABCDE
        n_checks++;
        if (imm !== 32'hABCD_E000 || alu_ctl !== 4'b1010 || alu_src !== 1'b1 || reg_write !== 1'b1)
            $display("FAIL lui: got imm=%h alu=%b src=%b rw=%b want abcde000 1010 1 1",
                     imm, alu_ctl, alu_src, reg_write);
        else n_pass++;
        n_checks++;
        if (s_imm !== 64'hFFFF_FFFF_ABCD_E000) $display("FAIL lui_64: got %h want ffffffffabcde000", s_imm);
        else n_pass++;
    endtask

    task automatic test_num_regs16();
        load(32'h0020_88B3, 32'h500);             // add x17,x1,x2
        n_checks++;
        if (s_illegal !== 1'b1 || s_reg_write !== 1'b0)
            $display("FAIL x17_illegal_16: got ill=%b rw=%b want 1 0", s_illegal, s_reg_write);
        else n_pass++;
        n_checks++;
        if (illegal !== 1'b0 || reg_write !== 1'b1)
            $display("FAIL x17_legal_32: got ill=%b rw=%b want 0 1", illegal, reg_write);
        else n_pass++;
        wb_write(5'd20, 32'h0000_CAFE);
        load(32'h0142_04B3, 32'h504);             // add x9,x4,x20
        n_checks++;
        if (s_dataA !== 64'd0 || s_dataB !== 64'd0)
            $display("FAIL x20_ignored_16: got A=%h B=%h want 0 0", s_dataA, s_dataB);
        else n_pass++;
        n_checks++;
        if (dataB !== 32'h0000_CAFE) $display("FAIL x20_written_32: got %h want cafe", dataB);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        load(32'h0052_8333, 32'h600);             // add x6,x5,x5
        n_checks++;
        if (valid !== 1'b1 || reg_write !== 1'b1)
            $display("FAIL pre_reset: got v=%b rw=%b want 1 1", valid, reg_write);
        else n_pass++;
        #2 i_rst = 1'b1;
        #1;
        n_checks++;
        if (strobes !== 8'h00 || rdes !== 5'd0 || pc !== 32'd0 || imm !== 32'd0)
            $display("FAIL async_reset: got st=%b rd=%0d pc=%h imm=%h want all 0", strobes, rdes, pc, imm);
        else n_pass++;
        #1 i_rst = 1'b0;
        load(32'h0052_8333, 32'h604);
        n_checks++;
        if (dataA !== 32'd0 || valid !== 1'b1)
            $display("FAIL regs_cleared: got A=%h v=%b want 0 1", dataA, valid);
        else n_pass++;
    endtask

    initial begin
        i_rst          = 1'b1;
        i_instr_F      = 32'h0000_0013;
        i_pc_F         = '0;
        i_pc_plus4_F   = '0;
        i_stall_D      = 1'b0;
        i_flush_D      = 1'b0;
        i_result_WB    = '0;
        i_addr_des_WB  = '0;
        i_reg_write_WB = 1'b0;
        test_reset();
        test_regfile_read();
        test_wb_same_cycle();
        test_stall_flush();
        test_decode();
        test_imm();
        test_num_regs16();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
